hdmi_pll_ctrl: RTL and testbench
================================

# hdmi_pll_ctrl

Sequencer for the HDMI pixel/serial PLL that exposes dynamic charge-pump and loop-filter controls. It drives the PLL reset and the loop-filter settings, then waits for lock and qualifies it as stable. It recovers from lock loss and timeouts by retrying, and gives up after a bounded number of attempts. It sits between the board clock domain and the PLL primitive wrapper, and gates the downstream HDMI/framebuffer logic through `clk_ok`.

## Interface
Parameters:
- `RST_CYCLES`, 64: PLL reset pulse width in `clk` cycles, 1..65535.
- `LOCK_TIMEOUT`, 65535: maximum cycles to wait for lock after reset release.
- `STABLE_CYCLES`, 1024: consecutive cycles synchronized lock must stay high before `clk_ok`.
- `MAX_RETRY`, 7: number of timeouts tolerated before FAIL, 1..15.
- `ICP_DEFAULT` 6'd16, `RES_DEFAULT` 3'd2, `CAP_DEFAULT` 2'd0: loop settings applied out of reset.

Ports:
- `clk` in 1: free-running board clock, not the PLL output.
- `resetn` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: new loop-setting request.
- `cfg_ready` out 1: request accepted when `cfg_valid & cfg_ready`.
- `cfg_icp` in 6, `cfg_res` in 3, `cfg_cap` in 2: requested loop settings.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `pll_reset` out 1: PLL reset, active high.
- `pll_icpsel` out 6, `pll_lpfres` out 3, `pll_lpfcap` out 2: registered loop settings to the PLL.
- `clk_ok` out 1: PLL locked and qualified.
- `fail` out 1: retries exhausted.
- `retry_cnt` out 4: timeouts in the current attempt sequence.
- `lock_loss_cnt` out 8: saturating count of lock losses while in RUN.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to form `lock_s`; all decisions use `lock_s`.
- One 16-bit down-counter `cnt` is shared by all timed states.
- States and transitions:
  - **RST**: `pll_reset`=1. Lasts exactly `RST_CYCLES` cycles, then goes to LOCKWAIT with `cnt`=`LOCK_TIMEOUT`.
  - **LOCKWAIT**: `pll_reset`=0.
    - `lock_s`=1 → STABLE with `cnt`=`STABLE_CYCLES`.
    - `cnt` reaches 0 → `retry_cnt`+1. If the new value equals `MAX_RETRY` → FAIL, else → RST.
  - **STABLE**: `lock_s`=0 → LOCKWAIT with a fresh timeout; `retry_cnt` is unchanged. After `STABLE_CYCLES` consecutive high cycles → RUN, `clk_ok`=1, `retry_cnt`=0.
  - **RUN**:
    - `lock_s`=0 → RST, `clk_ok`=0, `lock_loss_cnt`+1 saturating at 255.
    - Accepted cfg → RST.
  - **FAIL**: `pll_reset`=1, `fail`=1. Left only by an accepted cfg, which also clears `fail` and `retry_cnt`.
- `cfg_ready`=1 only in RUN and FAIL.
- On acceptance, `cfg_*` is latched into `pll_icpsel/lpfres/lpfcap` on the same edge that enters RST. The PLL therefore always sees new settings while held in reset.
- Simultaneous lock loss and `cfg_valid` in RUN: the cfg is accepted (settings latched), and `lock_loss_cnt` still increments.

## Timing
- Reset values:
  - `pll_reset`=1, state RST with `cnt`=`RST_CYCLES`.
  - Loop outputs = `*_DEFAULT`.
  - `clk_ok`=0, `fail`=0, `cfg_ready`=0, `retry_cnt`=0, `lock_loss_cnt`=0.
  - Synchronizer flops = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `pll_reset` is high for exactly `RST_CYCLES` cycles per RST entry (`RST_CYCLES`+0 after `resetn` deassert).
- `pll_lock` rise to `clk_ok` rise, lock held: 2 (sync) + 1 (LOCKWAIT→STABLE) + `STABLE_CYCLES` cycles.
- `pll_lock` fall in RUN to `clk_ok` fall: 3 cycles.
- `resetn` assertion mid-sequence immediately forces reset values, including `pll_reset`=1.

## Configuration
- `HDMI_PLL_CTRL_LOSS_CNT_EN` defined: the `lock_loss_cnt` register and its increment logic are built.
- Not defined: `lock_loss_cnt` is tied to 8'd0 and no register is inferred. All other behaviour is identical.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRY`=2.
- Release `resetn`, raise `pll_lock` 10 cycles later → `pll_reset` high exactly 4 cycles; `clk_ok`=1 exactly 11 cycles after `pll_lock` rise; loop outputs = 16/2/0.
- `pll_lock` never rises → two timeouts, each 4 reset + 20 wait cycles; then `fail`=1, `retry_cnt`=2, `pll_reset` held 1, `cfg_ready`=1.
- In FAIL, cfg 6'd40/3'd5/2'd1 with `cfg_valid` for 1 cycle, then lock → `pll_icpsel`=40 on the RST entry edge with `pll_reset`=1; `fail`=0; `clk_ok` returns.
- Lock glitch low 1 cycle during STABLE → counter restarts; `clk_ok` is delayed by the full 8 cycles; `retry_cnt` unchanged.
- In RUN, drop `pll_lock` → `clk_ok`=0 after 3 cycles, 4-cycle reset pulse, `lock_loss_cnt`=1 (0 with macro undefined). 300 losses → 255.
- Assert `resetn`=0 during LOCKWAIT → `pll_reset`=1, `clk_ok`=0, `retry_cnt`=0 immediately, with no clock edge.

Source files
------------

// File: rtl/hdmi_pll_ctrl.sv
// rtl/hdmi_pll_ctrl.sv - HDMI PLL reset/lock sequencer with retry, lock qualification and loop-setting control
// Optional build macro: HDMI_PLL_CTRL_LOSS_CNT_EN (builds the saturating lock-loss counter; otherwise lock_loss_cnt is tied to zero)
module hdmi_pll_ctrl #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 7,
    parameter logic [5:0]  ICP_DEFAULT   = 6'd16,
    parameter logic [2:0]  RES_DEFAULT   = 3'd2,
    parameter logic [1:0]  CAP_DEFAULT   = 2'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_icp,
    input  logic [2:0] cfg_res,
    input  logic [1:0] cfg_cap,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_icpsel,
    output logic [2:0] pll_lpfres,
    output logic [1:0] pll_lpfcap,
    output logic       clk_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_LOCKWAIT = 3'd1,
        S_STABLE   = 3'd2,
        S_RUN      = 3'd3,
        S_FAIL     = 3'd4
    } state_t;

    localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES);
    localparam logic [15:0] WAIT_LOAD   = 16'(LOCK_TIMEOUT);
    localparam logic [15:0] STABLE_LOAD = 16'(STABLE_CYCLES);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    logic       sync1_q;
    logic       lock_s_q;
    state_t     state_q;
    logic [15:0] cnt_q;
    logic       pll_reset_q;
    logic       clk_ok_q;
    logic       fail_q;
    logic       cfg_ready_q;
    logic [3:0] retry_q;
    logic [5:0] icp_q;
    logic [2:0] res_q;
    logic [1:0] cap_q;

    logic       cfg_accept;
    logic       cnt_expired;
    logic [3:0] retry_inc;

    // cfg_ready_q is high exactly in RUN and FAIL, so acceptance needs no state decode here
    assign cfg_accept  = cfg_valid & cfg_ready_q;
    // Shared down-counter: the last cycle of a timed state is the one that sees 1
    assign cnt_expired = (cnt_q <= 16'd1);
    assign retry_inc   = retry_q + 4'd1;

    // Two-flop synchronizer for the PLL lock, which is asynchronous to clk
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Sequencer: every output is updated on the same edge as the state it belongs to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_RST;
            cnt_q       <= RST_LOAD;
            pll_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            retry_q     <= 4'd0;
            icp_q       <= ICP_DEFAULT;
            res_q       <= RES_DEFAULT;
            cap_q       <= CAP_DEFAULT;
        end else begin
            case (state_q)
                S_RST: begin
                    if (cnt_expired) begin
                        state_q     <= S_LOCKWAIT;
                        cnt_q       <= WAIT_LOAD;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_LOCKWAIT: begin
                    if (lock_s_q) begin
                        state_q <= S_STABLE;
                        cnt_q   <= STABLE_LOAD;
                    end else if (cnt_expired) begin
                        // Timeout: count it and either retry the reset or give up
                        retry_q     <= retry_inc;
                        pll_reset_q <= 1'b1;
                        cnt_q       <= RST_LOAD;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_q     <= S_FAIL;
                            fail_q      <= 1'b1;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RST;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s_q) begin
                        // A glitch is not a timeout: wait again without touching retry_q
                        state_q <= S_LOCKWAIT;
                        cnt_q   <= WAIT_LOAD;
                    end else if (cnt_expired) begin
                        state_q     <= S_RUN;
                        clk_ok_q    <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        retry_q     <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q || cfg_accept) begin
                        state_q     <= S_RST;
                        cnt_q       <= RST_LOAD;
                        pll_reset_q <= 1'b1;
                        clk_ok_q    <= 1'b0;
                        cfg_ready_q <= 1'b0;
                    end
                    // New settings land on the RST entry edge so the PLL only sees them in reset
                    if (cfg_accept) begin
                        icp_q <= cfg_icp;
                        res_q <= cfg_res;
                        cap_q <= cfg_cap;
                    end
                end
                S_FAIL: begin
                    if (cfg_accept) begin
                        state_q     <= S_RST;
                        cnt_q       <= RST_LOAD;
                        fail_q      <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        retry_q     <= 4'd0;
                        icp_q       <= cfg_icp;
                        res_q       <= cfg_res;
                        cap_q       <= cfg_cap;
                    end
                end
                default: begin
                    state_q     <= S_RST;
                    cnt_q       <= RST_LOAD;
                    pll_reset_q <= 1'b1;
                    clk_ok_q    <= 1'b0;
                    fail_q      <= 1'b0;
                    cfg_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       lock_lost;

    assign lock_lost = (state_q == S_RUN) && !lock_s_q;

    // Count lock losses seen in RUN, saturating so a flapping PLL never wraps back to zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= 8'd0;
        end else if (lock_lost && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign pll_reset  = pll_reset_q;
    assign clk_ok     = clk_ok_q;
    assign fail       = fail_q;
    assign cfg_ready  = cfg_ready_q;
    assign retry_cnt  = retry_q;
    assign pll_icpsel = icp_q;
    assign pll_lpfres = res_q;
    assign pll_lpfcap = cap_q;

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// tb/tb_hdmi_pll_ctrl.sv - self-checking bench for hdmi_pll_ctrl with an elapsed-time behavioural model
module tb_hdmi_pll_ctrl;

    localparam int RST_C  = 4;
    localparam int WAIT_C = 20;
    localparam int STAB_C = 8;
    localparam int MAXR   = 2;
`ifdef HDMI_PLL_CTRL_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_icp = 6'd0;
    logic [2:0] cfg_res = 3'd0;
    logic [1:0] cfg_cap = 2'd0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_icpsel;
    logic [2:0] pll_lpfres;
    logic [1:0] pll_lpfcap;
    logic       clk_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    hdmi_pll_ctrl #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(WAIT_C), .STABLE_CYCLES(STAB_C), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_icp(cfg_icp), .cfg_res(cfg_res), .cfg_cap(cfg_cap), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_icpsel(pll_icpsel), .pll_lpfres(pll_lpfres),
        .pll_lpfcap(pll_lpfcap), .clk_ok(clk_ok), .fail(fail), .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode plus cycles elapsed in it, lock seen through a two-sample delay
    localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;
    int         m_mode = M_RST;
    int         m_t = 0;
    int         m_retry = 0;
    int         m_loss = 0;
    bit         m_seen[2] = '{1'b0, 1'b0};
    bit         m_ls;
    bit         m_acc;
    logic [5:0] m_icp = 6'd16;
    logic [2:0] m_res = 3'd2;
    logic [1:0] m_cap = 2'd0;
    bit         cmp_en = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode = M_RST; m_t = 0; m_retry = 0; m_loss = 0;
            m_seen[0] = 1'b0; m_seen[1] = 1'b0;
            m_icp = 6'd16; m_res = 3'd2; m_cap = 2'd0;
        end else begin
            m_ls = m_seen[1];
            m_seen[1] = m_seen[0];
            m_seen[0] = pll_lock;
            m_acc = cfg_valid && (m_mode == M_RUN || m_mode == M_FAIL);
            if (m_acc) begin
                m_icp = cfg_icp; m_res = cfg_res; m_cap = cfg_cap;
            end
            case (m_mode)
                M_RST: begin
                    m_t++;
                    if (m_t == RST_C) begin m_mode = M_WAIT; m_t = 0; end
                end
                M_WAIT: begin
                    if (m_ls) begin
                        m_mode = M_STAB; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == WAIT_C) begin
                            m_retry++;
                            m_mode = (m_retry == MAXR) ? M_FAIL : M_RST;
                            m_t = 0;
                        end
                    end
                end
                M_STAB: begin
                    if (!m_ls) begin
                        m_mode = M_WAIT; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == STAB_C) begin m_mode = M_RUN; m_retry = 0; m_t = 0; end
                    end
                end
                M_RUN: begin
                    if (!m_ls && m_loss < 255) m_loss++;
                    if (!m_ls || m_acc) begin m_mode = M_RST; m_t = 0; end
                end
                default: begin
                    if (m_acc) begin m_mode = M_RST; m_t = 0; m_retry = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pll_reset", 32'(pll_reset), 32'(m_mode == M_RST || m_mode == M_FAIL));
            chk("m_clk_ok", 32'(clk_ok), 32'(m_mode == M_RUN));
            chk("m_fail", 32'(fail), 32'(m_mode == M_FAIL));
            chk("m_cfg_ready", 32'(cfg_ready), 32'(m_mode == M_RUN || m_mode == M_FAIL));
            chk("m_retry_cnt", 32'(retry_cnt), 32'(m_retry));
            chk("m_loss_cnt", 32'(lock_loss_cnt), LOSS_EN ? 32'(m_loss) : 32'd0);
            chk("m_icpsel", 32'(pll_icpsel), 32'(m_icp));
            chk("m_lpfres", 32'(pll_lpfres), 32'(m_res));
            chk("m_lpfcap", 32'(pll_lpfcap), 32'(m_cap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Length of the current run of pll_reset at level lvl, counted in negedges
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (n < 200 && pll_reset === lvl) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Rising clock edges until clk_ok reaches lvl, observed at the following negedge
    task automatic wait_ok(input logic lvl, output int k);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (clk_ok !== lvl && k < 300);
    endtask

    initial begin
        int n;
        int k;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_icp", 32'(pll_icpsel), 32'd16);
        chk("rst_res", 32'(pll_lpfres), 32'd2);
        chk("rst_cap", 32'(pll_lpfcap), 32'd0);
        chk("rst_clk_ok", 32'(clk_ok), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);

        // First lock-up after reset release
        tick();
        resetn = 1'b1;
        @(negedge clk);
        run_len(1'b1, n);
        chk("first_rst_pulse", 32'(n), 32'd4);
        repeat (6) tick();
        pll_lock = 1'b1;
        wait_ok(1'b1, k);
        chk("lock_to_clk_ok", 32'(k), 32'd11);
        chk("run_icp", 32'(pll_icpsel), 32'd16);

        // Lock loss in RUN
        tick();
        pll_lock = 1'b0;
        wait_ok(1'b0, k);
        chk("loss_to_clk_ok_fall", 32'(k), 32'd3);
        run_len(1'b1, n);
        chk("loss_rst_pulse", 32'(n), 32'd4);
        chk("loss_cnt_1", 32'(lock_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);

        // Lock never returns: two timeouts then FAIL
        run_len(1'b0, n);
        chk("timeout1_wait", 32'(n), 32'd20);
        run_len(1'b1, n);
        chk("timeout_rst", 32'(n), 32'd4);
        run_len(1'b0, n);
        chk("timeout2_wait", 32'(n), 32'd20);
        chk("fail_set", 32'(fail), 32'd1);
        chk("fail_retry", 32'(retry_cnt), 32'd2);
        chk("fail_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("fail_pll_reset_held", 32'(pll_reset), 32'd1);

        // New settings out of FAIL
        tick();
        cfg_valid = 1'b1; cfg_icp = 6'd40; cfg_res = 3'd5; cfg_cap = 2'd1;
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_icp_on_entry", 32'(pll_icpsel), 32'd40);
        chk("cfg_pll_reset_on_entry", 32'(pll_reset), 32'd1);
        chk("cfg_fail_cleared", 32'(fail), 32'd0);
        chk("cfg_retry_cleared", 32'(retry_cnt), 32'd0);
        tick();
        pll_lock = 1'b1;
        wait_ok(1'b1, k);
        chk("cfg_clk_ok_back", 32'(clk_ok), 32'd1);
        chk("cfg_res_kept", 32'(pll_lpfres), 32'd5);

        // One timeout, then a one-cycle lock glitch during STABLE
        tick();
        pll_lock = 1'b0;
        wait_ok(1'b0, k);
        run_len(1'b1, n);
        run_len(1'b0, n);
        run_len(1'b1, n);
        chk("glitch_retry_pre", 32'(retry_cnt), 32'd1);
        tick();
        pll_lock = 1'b1;
        repeat (4) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        @(negedge clk);
        wait_ok(1'b1, k);
        chk("glitch_restart_delay", 32'(k), 32'd11);
        chk("glitch_retry_cleared", 32'(retry_cnt), 32'd0);

        // Lock loss and cfg on the same RUN cycle
        tick();
        pll_lock = 1'b0;
        tick();
        tick();
        cfg_valid = 1'b1; cfg_icp = 6'd7; cfg_res = 3'd1; cfg_cap = 2'd3;
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("simul_icp", 32'(pll_icpsel), 32'd7);
        chk("simul_cap", 32'(pll_lpfcap), 32'd3);
        chk("simul_pll_reset", 32'(pll_reset), 32'd1);
        chk("simul_loss", 32'(lock_loss_cnt), LOSS_EN ? 32'd3 : 32'd0);
        tick();
        pll_lock = 1'b1;
        wait_ok(1'b1, k);

        // Many losses: counter saturates
        for (int i = 0; i < 300; i++) begin
            tick();
            pll_lock = 1'b0;
            wait_ok(1'b0, k);
            tick();
            pll_lock = 1'b1;
            wait_ok(1'b1, k);
            if (clk_ok !== 1'b1) break;
        end
        chk("loss_saturated", 32'(lock_loss_cnt), LOSS_EN ? 32'd255 : 32'd0);

        // Asynchronous reset in LOCKWAIT with a nonzero retry count
        tick();
        pll_lock = 1'b0;
        wait_ok(1'b0, k);
        run_len(1'b1, n);
        run_len(1'b0, n);
        run_len(1'b1, n);
        chk("async_retry_pre", 32'(retry_cnt), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_pll_reset", 32'(pll_reset), 32'd1);
        chk("async_clk_ok", 32'(clk_ok), 32'd0);
        chk("async_retry", 32'(retry_cnt), 32'd0);
        chk("async_fail", 32'(fail), 32'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
